ls_writeback_unit: RTL and testbench

- Load/store and writeback stage directly downstream of RegBlock.
- Consumes ALUresult, used as the byte address or as the ALU value, and opBwd, used as store data.
- Runs a data-memory request/acknowledge handshake and drives the register-file write port (rd, wd, we) back into RegBlock.
- Holds off upstream with in_ready while a memory access is outstanding.

---
 rtl/ls_pkg.sv | 26 ++
 rtl/ls_timeout_ctr.sv | 32 +++
 rtl/ls_writeback_unit.sv | 176 +++++++++++++++++
 tb/tb_ls_writeback_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ls_pkg.sv
// Shared types and constants for the load/store writeback stage.
//   op_t    : instruction operation code as presented by RegBlock
//   state_t : sequencing state of ls_writeback_unit
package ls_pkg;

  localparam int unsigned DWIDTH = 32;
  localparam int unsigned RWIDTH = 6;

  typedef enum logic [1:0] {
    OP_ALU   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_NOP   = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEM,
    S_WB
  } state_t;

  function automatic logic is_mem_op(input op_t o);
    return (o == OP_LOAD) || (o == OP_STORE);
  endfunction

endpackage

// File: rtl/ls_timeout_ctr.sv
// Memory-access watchdog counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart counting from zero (takes priority over enable)
//   enable     : advance by one this cycle
//   expired    : count has reached TIMEOUT-1
module ls_timeout_ctr #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/ls_writeback_unit.sv
// Load/store and writeback stage downstream of RegBlock.
//   in_valid/in_ready        : upstream handshake; ready only while idle
//   op, alu_result,
//   store_data, rd_in        : instruction fields captured on accept
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_rdata/
//   mem_ack                  : data-memory request/acknowledge port
//   we, rd, wd               : register-file write port back into RegBlock
//   err_misalign             : pulse for an unaligned LOAD/STORE
//   err_timeout              : pulse when mem_ack never arrived
module ls_writeback_unit
  import ls_pkg::*;
#(
  parameter int unsigned DWIDTH  = ls_pkg::DWIDTH,
  parameter int unsigned RWIDTH  = ls_pkg::RWIDTH,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op,
  input  logic [DWIDTH-1:0] alu_result,
  input  logic [DWIDTH-1:0] store_data,
  input  logic [RWIDTH-1:0] rd_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              we,
  output logic [RWIDTH-1:0] rd,
  output logic [DWIDTH-1:0] wd,
  output logic              err_misalign,
  output logic              err_timeout
);

  state_t state_q, state_d;
  op_t    op_in;
  logic   accept;
  logic   aligned;
  logic   start_mem;
  logic   ctr_enable;
  logic   ctr_expired;

  logic              mem_req_d, mem_we_d;
  logic [DWIDTH-1:0] mem_addr_d, mem_wdata_d, wd_d;
  logic [RWIDTH-1:0] rd_d;
  logic              err_misalign_d, err_timeout_d;

  assign op_in     = op_t'(op);
  assign in_ready  = (state_q == S_IDLE);
  assign accept    = in_valid && in_ready;
  assign aligned   = (alu_result[1:0] == 2'b00);
  assign start_mem = accept && is_mem_op(op_in) && aligned;
  // Stalls only while waiting; an ack this cycle ends the access anyway.
  assign ctr_enable = (state_q == S_MEM) && !mem_ack;

  ls_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (start_mem),
    .enable  (ctr_enable),
    .expired (ctr_expired)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (op_in == OP_ALU) begin
            state_d = S_WB;
          end else if (start_mem) begin
            state_d = S_MEM;
          end
        end
      end
      S_MEM: begin
        // ack beats a simultaneous timeout
        if (mem_ack) begin
          state_d = mem_we ? S_IDLE : S_WB;
        end else if (ctr_expired) begin
          state_d = S_IDLE;
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    mem_req_d      = mem_req;
    mem_we_d       = mem_we;
    mem_addr_d     = mem_addr;
    mem_wdata_d    = mem_wdata;
    wd_d           = wd;
    rd_d           = rd;
    err_misalign_d = 1'b0;
    err_timeout_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (op_in == OP_ALU) begin
            wd_d = alu_result;
            rd_d = rd_in;
          end else if (is_mem_op(op_in)) begin
            if (!aligned) begin
              err_misalign_d = 1'b1;
            end else begin
              mem_req_d   = 1'b1;
              mem_we_d    = (op_in == OP_STORE);
              mem_addr_d  = alu_result;
              mem_wdata_d = store_data;
              if (op_in == OP_LOAD) begin
                rd_d = rd_in;
              end
            end
          end
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (!mem_we) begin
            wd_d = mem_rdata;
          end
        end else if (ctr_expired) begin
          mem_req_d     = 1'b0;
          err_timeout_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      wd           <= '0;
      rd           <= '0;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      mem_req      <= mem_req_d;
      mem_we       <= mem_we_d;
      mem_addr     <= mem_addr_d;
      mem_wdata    <= mem_wdata_d;
      wd           <= wd_d;
      rd           <= rd_d;
      err_misalign <= err_misalign_d;
      err_timeout  <= err_timeout_d;
    end
  end

  // Register 0 is hardwired; never write it.
  assign we = (state_q == S_WB) && (rd != '0);

endmodule

// File: tb/tb_ls_writeback_unit.sv
module tb_ls_writeback_unit;

  localparam int unsigned DW  = 32;
  localparam int unsigned RW  = 6;
  localparam int unsigned TMO = 16;
  localparam int unsigned NO_ACK = 1000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    op;
  logic [DW-1:0] alu_result;
  logic [DW-1:0] store_data;
  logic [RW-1:0] rd_in;
  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          we;
  logic [RW-1:0] rd;
  logic [DW-1:0] wd;
  logic          err_misalign;
  logic          err_timeout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ls_writeback_unit #(
    .DWIDTH  (DW),
    .RWIDTH  (RW),
    .TIMEOUT (TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op           (op),
    .alu_result   (alu_result),
    .store_data   (store_data),
    .rd_in        (rd_in),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .we           (we),
    .rd           (rd),
    .wd           (wd),
    .err_misalign (err_misalign),
    .err_timeout  (err_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One instruction, issued from idle. Expectations follow the stage's
  // transaction rules: ALU -> one WB cycle; misaligned -> error pulse only;
  // aligned access -> request held until ack (ack in MEM cycle 'delay')
  // or for TIMEOUT cycles, then WB / idle / timeout pulse.
  task automatic run_txn(input logic [1:0] o, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [5:0] r,
                         input int unsigned delay, input logic [31:0] rdata);
    int unsigned last;
    logic        acked;
    chk("pre_ready", in_ready, 1);
    in_valid   = 1'b1;
    op         = o;
    alu_result = addr;
    store_data = sdata;
    rd_in      = r;
    step();
    in_valid   = 1'b0;
    op         = 2'($urandom);
    alu_result = $urandom;
    store_data = $urandom;
    rd_in      = 6'($urandom);
    if (o == 2'b11) begin
      chk("nop_ready", in_ready, 1);
      chk("nop_we", we, 0);
      chk("nop_req", mem_req, 0);
    end else if (o == 2'b00) begin
      chk("alu_ready", in_ready, 0);
      chk("alu_we", we, (r != 0));
      chk("alu_rd", rd, r);
      chk("alu_wd", wd, addr);
      step();
      chk("alu_ready_after", in_ready, 1);
      chk("alu_we_after", we, 0);
    end else if (addr[1:0] != 2'b00) begin
      chk("mis_err", err_misalign, 1);
      chk("mis_req", mem_req, 0);
      chk("mis_we", we, 0);
      chk("mis_ready", in_ready, 1);
      step();
      chk("mis_err_after", err_misalign, 0);
    end else begin
      acked = (delay <= TMO - 1);
      last  = acked ? delay : TMO - 1;
      for (int unsigned k = 0; k <= last; k++) begin
        chk("mem_req", mem_req, 1);
        chk("mem_we", mem_we, (o == 2'b10));
        chk("mem_addr", mem_addr, addr);
        chk("mem_wdata", mem_wdata, sdata);
        chk("mem_ready", in_ready, 0);
        chk("mem_wen", we, 0);
        mem_ack   = (k == delay);
        mem_rdata = (k == delay) ? rdata : $urandom;
        step();
        mem_ack   = 1'b0;
      end
      chk("mem_req_drop", mem_req, 0);
      if (acked && o == 2'b01) begin
        chk("ld_ready", in_ready, 0);
        chk("ld_we", we, (r != 0));
        chk("ld_wd", wd, rdata);
        chk("ld_rd", rd, r);
        step();
        chk("ld_we_after", we, 0);
        chk("ld_ready_after", in_ready, 1);
      end else if (acked) begin
        chk("st_ready", in_ready, 1);
        chk("st_we", we, 0);
        chk("st_tmo", err_timeout, 0);
      end else begin
        chk("tmo_err", err_timeout, 1);
        chk("tmo_we", we, 0);
        chk("tmo_ready", in_ready, 1);
        step();
        chk("tmo_err_after", err_timeout, 0);
        chk("tmo_we_after", we, 0);
      end
    end
  endtask

  initial begin
    int pulses;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    op         = 2'b11;
    alu_result = '0;
    store_data = '0;
    rd_in      = '0;
    mem_rdata  = '0;
    mem_ack    = 1'b0;
    step();
    step();
    chk("rst_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_we", we, 0);
    chk("rst_rd", rd, 0);
    chk("rst_wd", wd, 0);
    chk("rst_errs", {err_misalign, err_timeout}, 0);
    rst_n = 1'b1;
    step();
    chk("rst_ready", in_ready, 1);

    // Directed cases
    run_txn(2'b00, 32'hFFAAFFAA, 32'h0, 6'h3F, 0, 32'h0);
    run_txn(2'b01, 32'h00000010, 32'h0, 6'h05, 3, 32'h12345678);
    run_txn(2'b10, 32'h00000020, 32'hAAAAAAAA, 6'h07, 1, 32'h0);
    run_txn(2'b01, 32'h00000013, 32'h0, 6'h09, 0, 32'h0);
    run_txn(2'b01, 32'h00000040, 32'h0, 6'h0A, NO_ACK, 32'h0);
    run_txn(2'b01, 32'h00000044, 32'h0, 6'h0B, TMO - 1, 32'hCAFEF00D);
    run_txn(2'b00, 32'h13572468, 32'h0, 6'h00, 0, 32'h0);
    run_txn(2'b11, 32'h00000004, 32'h0, 6'h01, 0, 32'h0);

    // Ack while idle is ignored
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("stray_ack_we", we, 0);
    chk("stray_ack_req", mem_req, 0);
    chk("stray_ack_ready", in_ready, 1);

    // Back-to-back ALU ops: one accepted every two cycles
    pulses     = 0;
    in_valid   = 1'b1;
    op         = 2'b00;
    rd_in      = 6'h01;
    alu_result = 32'h1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (we) pulses++;
    end
    in_valid = 1'b0;
    chk("b2b_pulses", pulses, 2);
    chk("b2b_ready", in_ready, 1);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      logic [1:0]  o;
      logic [31:0] a;
      logic [5:0]  r;
      int unsigned d;
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      r = ($urandom_range(0, 7) == 0) ? 6'h00 : 6'($urandom);
      d = ($urandom_range(0, 6) == 0) ? NO_ACK : $urandom_range(0, TMO + 2);
      run_txn(o, a, $urandom, r, d, $urandom);
    end

    // Reset during an outstanding access
    in_valid   = 1'b1;
    op         = 2'b01;
    alu_result = 32'h00000080;
    rd_in      = 6'h11;
    step();
    in_valid = 1'b0;
    step();
    chk("rstmid_req_before", mem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_req_async", mem_req, 0);
    chk("rstmid_ready", in_ready, 1);
    step();
    rst_n   = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      mem_ack = 1'b0;
      chk("rstmid_we", we, 0);
      chk("rstmid_req", mem_req, 0);
      chk("rstmid_errs", {err_misalign, err_timeout}, 0);
      chk("rstmid_ready_after", in_ready, 1);
    end
    chk("rstmid_wd", wd, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
